mac_array_ctrl: RTL and testbench
=================================

Name: mac_array_ctrl

Overview:
Sequencer for the 8x8 MAC array. On a start pulse it runs one tile: weight load (weight-stationary only), activation streaming with execute, then drain. It drives the array's 2-bit instruction and the read ports of the weight and activation SRAMs, and it counts array valid pulses to detect tile completion. It sits between the top-level core FSM and the mac_array/SRAM datapath.

Parameters:
row, 8, array rows (width of the in_w lanes)
col, 8, array columns
addr_w, 11, SRAM address width
len_w, 8, width of the tile length field

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  single-cycle tile start; ignored while busy
cfg_is_os  in  1  output-stationary mode for this tile
cfg_act_2b  in  1  2-bit activation mode for this tile
cfg_len  in  len_w  activation vectors to stream (K)
cfg_w_base  in  addr_w  weight SRAM base address
cfg_a_base  in  addr_w  activation SRAM base address
w_rd_en  out  1  weight SRAM read enable
w_rd_addr  out  addr_w  weight SRAM address
a_rd_en  out  1  activation SRAM read enable
a_rd_addr  out  addr_w  activation SRAM address
inst_w  out  2  to the array: [1] execute, [0] kernel load / OS shift-out
is_os  out  1  latched cfg_is_os, held for the whole tile
act_2b_mode  out  1  latched cfg_act_2b, held for the whole tile
valid  in  col  array valid; bit col-1 is used for counting
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at tile end

Behaviour:
- Reset: state IDLE, all outputs 0, all counters 0. Reset asserted mid-tile aborts the tile; the next cycle is IDLE with zero outputs and no done pulse.
- Start acceptance: start in IDLE latches all cfg_* into registers. is_os and act_2b_mode update the same edge. Start while busy has no effect.
- SRAM reads have 1-cycle latency. inst_w is a registered copy of the phase's read command, delayed one cycle, so it aligns with returning data.
- States:
  - IDLE -> WLOAD when start is accepted and is_os=0.
  - IDLE -> EXEC when start is accepted and is_os=1.
  - IDLE -> DONE when start is accepted and cfg_len=0; no reads are issued.
  - WLOAD: col cycles with w_rd_en=1 and w_rd_addr = w_base + n (n=0..col-1). inst_w=01 on the following col cycles. Then -> GAP.
  - GAP: one cycle with all enables 0, to flush the load from the inst pipeline. Then -> EXEC.
  - EXEC: cfg_len cycles with a_rd_en=1 and a_rd_addr = a_base + k. inst_w=10 one cycle later. Then -> DRAIN (WS) or SHIFT (OS).
  - SHIFT (OS only): row cycles with inst_w=01 to shift accumulated psums south. Then -> DRAIN.
  - DRAIN: enables 0, inst_w=00; wait until the valid count reaches its target. Then -> DONE.
  - DONE: done=1 for one cycle, busy drops the same cycle. Then -> IDLE.
- Valid counting:
  - The counter is cleared on start and increments on each cycle with valid[col-1]=1 during EXEC, SHIFT or DRAIN.
  - Target is cfg_len for WS and row for OS.
  - Valid pulses arriving in IDLE are ignored.
  - The counter saturates at the target; extra pulses do not overflow it.
- Address arithmetic is modulo 2^addr_w and wraps silently.
- Counters are len_w bits wide; cfg_len=255 is legal.

Decomposition:
- Package mac_ctrl_pkg holds:
  - state enum (IDLE, WLOAD, GAP, EXEC, SHIFT, DRAIN, DONE);
  - inst encodings INST_NOP=00, INST_LOAD=01, INST_EXEC=10.
- One sub-module, mac_ctrl_valid_cnt: saturating counter with clear, increment and target-compare. Everything else lives in the top FSM.

Test Plan:
- WS tile, w_base=0x010, a_base=0x100, len=4:
  - w_rd_addr 0x010..0x017 on 8 consecutive cycles;
  - inst_w=01 for 8 cycles starting one cycle later;
  - one GAP cycle;
  - a_rd_addr 0x100..0x103, with inst_w=10 for 4 cycles one cycle later;
  - done 1 cycle after the 4th valid[7] pulse;
  - is_os=0 throughout.
- OS tile, len=3, act_2b=1:
  - no weight reads;
  - inst_w=10 for 3 cycles, then 01 for 8 cycles;
  - done after 8 valid[7] pulses;
  - act_2b_mode=1 held from the start edge to done.
- len=0: start -> DONE the next cycle; done pulses once; no rd_en is ever asserted.
- Start re-pulsed mid-EXEC with different cfg: ignored; addresses and mode unchanged; exactly one done.
- Reset asserted during WLOAD cycle 3: next cycle all outputs 0 and state IDLE. A fresh start then runs a full, correct tile.
- a_base=0x7FE, len=4: a_rd_addr sequence 0x7FE, 0x7FF, 0x000, 0x001. Extra valid pulses during DRAIN do not delay or duplicate done.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// Shared types for the MAC array sequencer.
//   state_e  : tile sequencing states
//   INST_*   : 2-bit array instruction encodings ([1] execute, [0] load / OS shift-out)
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWload,
    StGap,
    StExec,
    StShift,
    StDrain,
    StDone
  } state_e;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_ctrl_valid_cnt.sv
// Saturating counter of array valid pulses for tile-completion detection.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : zero the count (tile start); wins over inc
//   inc         : count one pulse this cycle (ignored once target is reached)
//   target      : count at which the tile is complete
//   reach_next  : count after this cycle's update equals target
module mac_ctrl_valid_cnt #(
  parameter int unsigned len_w = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [len_w-1:0] target,
  output logic             reach_next
);

  logic [len_w-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q < target)) begin
      count_d = count_q + len_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Looks at the post-update value so a pulse on the last needed cycle ends DRAIN immediately.
  assign reach_next = (count_d == target);

endmodule

// File: rtl/mac_array_ctrl.sv
// Tile sequencer for the MAC array: weight load (WS only), activation streaming with
// execute, OS shift-out, then drain until the array has produced all expected rows.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   start                    : one-cycle tile start, honoured only in IDLE
//   cfg_is_os, cfg_act_2b    : tile mode, latched on start
//   cfg_len                  : activation vectors to stream (0 = empty tile)
//   cfg_w_base, cfg_a_base   : SRAM base addresses, latched on start
//   w_rd_en/w_rd_addr        : weight SRAM read port
//   a_rd_en/a_rd_addr        : activation SRAM read port
//   inst_w                   : array instruction, one cycle behind the matching read
//   is_os, act_2b_mode       : latched tile mode
//   valid                    : array valid; only the last column is counted
//   busy, done               : tile in progress / one-cycle completion pulse
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned row    = 8,
  parameter int unsigned col    = 8,
  parameter int unsigned addr_w = 11,
  parameter int unsigned len_w  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_is_os,
  input  logic              cfg_act_2b,
  input  logic [len_w-1:0]  cfg_len,
  input  logic [addr_w-1:0] cfg_w_base,
  input  logic [addr_w-1:0] cfg_a_base,
  output logic              w_rd_en,
  output logic [addr_w-1:0] w_rd_addr,
  output logic              a_rd_en,
  output logic [addr_w-1:0] a_rd_addr,
  output logic [1:0]        inst_w,
  output logic              is_os,
  output logic              act_2b_mode,
  input  logic [col-1:0]    valid,
  output logic              busy,
  output logic              done
);

  localparam logic [len_w-1:0] ColLast = len_w'(col - 1);
  localparam logic [len_w-1:0] RowLast = len_w'(row - 1);

  state_e            state_q, state_d;
  logic [len_w-1:0]  cnt_q, cnt_d;
  logic [len_w-1:0]  len_q;
  logic [addr_w-1:0] w_base_q, a_base_q;
  logic              is_os_q, act_2b_q;
  logic [1:0]        inst_q, inst_d;
  logic              start_ok;
  logic              cnt_inc;
  logic              reach_next;
  logic [len_w-1:0]  target;
  logic              unused_valid;

  assign unused_valid = ^valid[col-2:0];

  assign start_ok = start && (state_q == StIdle);
  assign target   = is_os_q ? len_w'(row) : len_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    inst_d    = INST_NOP;
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    a_rd_en   = 1'b0;
    a_rd_addr = '0;
    busy      = 1'b0;
    done      = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d = '0;
          if (cfg_len == '0) begin
            state_d = StDone;
          end else if (cfg_is_os) begin
            state_d = StExec;
          end else begin
            state_d = StWload;
          end
        end
      end
      StWload: begin
        busy      = 1'b1;
        w_rd_en   = 1'b1;
        w_rd_addr = w_base_q + addr_w'(cnt_q);
        inst_d    = INST_LOAD;
        if (cnt_q == ColLast) begin
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + len_w'(1);
        end
      end
      StGap: begin
        // Lets the last LOAD leave the inst pipeline before EXEC reads begin.
        busy    = 1'b1;
        state_d = StExec;
      end
      StExec: begin
        busy      = 1'b1;
        a_rd_en   = 1'b1;
        a_rd_addr = a_base_q + addr_w'(cnt_q);
        inst_d    = INST_EXEC;
        cnt_inc   = valid[col-1];
        if (cnt_q == len_q - len_w'(1)) begin
          cnt_d   = '0;
          state_d = is_os_q ? StShift : StDrain;
        end else begin
          cnt_d = cnt_q + len_w'(1);
        end
      end
      StShift: begin
        busy    = 1'b1;
        inst_d  = INST_LOAD;
        cnt_inc = valid[col-1];
        if (cnt_q == RowLast) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + len_w'(1);
        end
      end
      StDrain: begin
        busy    = 1'b1;
        cnt_inc = valid[col-1];
        if (reach_next) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      inst_q   <= INST_NOP;
      len_q    <= '0;
      w_base_q <= '0;
      a_base_q <= '0;
      is_os_q  <= 1'b0;
      act_2b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      if (start_ok) begin
        len_q    <= cfg_len;
        w_base_q <= cfg_w_base;
        a_base_q <= cfg_a_base;
        is_os_q  <= cfg_is_os;
        act_2b_q <= cfg_act_2b;
      end
    end
  end

  assign inst_w      = inst_q;
  assign is_os       = is_os_q;
  assign act_2b_mode = act_2b_q;

  mac_ctrl_valid_cnt #(
    .len_w(len_w)
  ) u_valid_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .inc       (cnt_inc),
    .target    (target),
    .reach_next(reach_next)
  );

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl: each tile pushes its expected read addresses,
// instructions and done time (relative to the start edge); a monitor pops and compares.
module tb_mac_array_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cfg_is_os = 1'b0;
  logic        cfg_act_2b = 1'b0;
  logic [7:0]  cfg_len = 8'd0;
  logic [10:0] cfg_w_base = 11'd0;
  logic [10:0] cfg_a_base = 11'd0;
  logic        w_rd_en, a_rd_en;
  logic [10:0] w_rd_addr, a_rd_addr;
  logic [1:0]  inst_w;
  logic        is_os, act_2b_mode, busy, done;
  logic [7:0]  valid = 8'd0;

  typedef struct {
    int          rel;
    logic [10:0] val;
  } ev_t;

  ev_t  w_q[$];
  ev_t  a_q[$];
  ev_t  i_q[$];
  int   d_q[$];
  ev_t  me;
  int   md;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  bit   active = 1'b0;
  bit   got_done = 1'b0;
  logic exp_os = 1'b0;
  logic exp_a2 = 1'b0;

  mac_array_ctrl #(
    .row   (8),
    .col   (8),
    .addr_w(11),
    .len_w (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_is_os  (cfg_is_os),
    .cfg_act_2b (cfg_act_2b),
    .cfg_len    (cfg_len),
    .cfg_w_base (cfg_w_base),
    .cfg_a_base (cfg_a_base),
    .w_rd_en    (w_rd_en),
    .w_rd_addr  (w_rd_addr),
    .a_rd_en    (a_rd_en),
    .a_rd_addr  (a_rd_addr),
    .inst_w     (inst_w),
    .is_os      (is_os),
    .act_2b_mode(act_2b_mode),
    .valid      (valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (w_rd_en) begin
      checks++;
      if (w_q.size() == 0) begin
        errors++;
        $display("FAIL w_rd unexpected: got addr=%h at rel %0d, required no read", w_rd_addr,
                 cyc - t0);
      end else begin
        me = w_q.pop_front();
        if (me.rel !== cyc - t0 || me.val !== w_rd_addr) begin
          errors++;
          $display("FAIL w_rd: got addr=%h rel=%0d, required addr=%h rel=%0d", w_rd_addr,
                   cyc - t0, me.val, me.rel);
        end
      end
    end
    if (a_rd_en) begin
      checks++;
      if (a_q.size() == 0) begin
        errors++;
        $display("FAIL a_rd unexpected: got addr=%h at rel %0d, required no read", a_rd_addr,
                 cyc - t0);
      end else begin
        me = a_q.pop_front();
        if (me.rel !== cyc - t0 || me.val !== a_rd_addr) begin
          errors++;
          $display("FAIL a_rd: got addr=%h rel=%0d, required addr=%h rel=%0d", a_rd_addr,
                   cyc - t0, me.val, me.rel);
        end
      end
    end
    if (inst_w !== 2'b00) begin
      checks++;
      if (i_q.size() == 0) begin
        errors++;
        $display("FAIL inst unexpected: got %b at rel %0d, required 00", inst_w, cyc - t0);
      end else begin
        me = i_q.pop_front();
        if (me.rel !== cyc - t0 || me.val[1:0] !== inst_w) begin
          errors++;
          $display("FAIL inst: got %b rel=%0d, required %b rel=%0d", inst_w, cyc - t0,
                   me.val[1:0], me.rel);
        end
      end
    end
    if (active) begin
      checks++;
      if (is_os !== exp_os || act_2b_mode !== exp_a2 || busy !== !done) begin
        errors++;
        $display("FAIL mode/busy rel %0d: got is_os=%b act_2b=%b busy=%b done=%b, required %b %b %b",
                 cyc - t0, is_os, act_2b_mode, busy, done, exp_os, exp_a2, !done);
      end
    end
    if (done) begin
      checks++;
      if (d_q.size() == 0) begin
        errors++;
        $display("FAIL done unexpected: got pulse at rel %0d, required none", cyc - t0);
      end else begin
        md = d_q.pop_front();
        if (md !== cyc - t0) begin
          errors++;
          $display("FAIL done time: got rel %0d, required rel %0d", cyc - t0, md);
        end
      end
      got_done = 1'b1;
      active   = 1'b0;
    end
  end

  // Pushes the expected trace for one tile, drives it and waits for done.
  // Pulses on valid[7] cover relative cycles p0..p0+np-1; a second start is pulsed at rel rs.
  task automatic drive_tile(input string name, input bit os, input bit a2, input int len,
                            input logic [10:0] wb, input logic [10:0] ab, input int p0,
                            input int np, input int rs);
    ev_t ev;
    int  e_rel, dr, tgt, cnt, rt, d_rel, r, budget;
    e_rel = os ? 0 : 9;
    if (len == 0) begin
      d_rel = 0;
    end else begin
      if (!os) begin
        for (int n = 0; n < 8; n++) begin
          ev.rel = n;     ev.val = wb + 11'(n); w_q.push_back(ev);
          ev.rel = n + 1; ev.val = 11'd1;       i_q.push_back(ev);
        end
      end
      for (int k = 0; k < len; k++) begin
        ev.rel = e_rel + k;     ev.val = ab + 11'(k); a_q.push_back(ev);
        ev.rel = e_rel + k + 1; ev.val = 11'd2;       i_q.push_back(ev);
      end
      if (os) begin
        for (int s = 0; s < 8; s++) begin
          ev.rel = len + 1 + s; ev.val = 11'd1; i_q.push_back(ev);
        end
      end
      dr  = os ? len + 8 : len + 9;
      tgt = os ? 8 : len;
      cnt = 0;
      rt  = -1;
      for (int q = p0; q < p0 + np; q++) begin
        if (q >= e_rel && rt < 0) begin
          cnt++;
          if (cnt == tgt) rt = q;
        end
      end
      d_rel = ((rt > dr) ? rt : dr) + 1;
    end
    d_q.push_back(d_rel);

    @(negedge clk);
    cfg_is_os  = os;
    cfg_act_2b = a2;
    cfg_len    = 8'(len);
    cfg_w_base = wb;
    cfg_a_base = ab;
    start      = 1'b1;
    t0         = cyc + 1;
    exp_os     = os;
    exp_a2     = a2;
    got_done   = 1'b0;
    active     = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    budget = 0;
    while (!got_done && budget < 1000) begin
      r     = cyc - t0;
      valid = (r >= p0 && r < p0 + np) ? 8'h80 : 8'h00;
      if (r == rs) begin
        start      = 1'b1;
        cfg_is_os  = ~os;
        cfg_act_2b = ~a2;
        cfg_len    = 8'd2;
        cfg_w_base = 11'h555;
        cfg_a_base = 11'h2AA;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      budget++;
    end
    valid = 8'h00;
    start = 1'b0;
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL %s done timeout: got no done in %0d cycles, required done at rel %0d",
               name, budget, d_rel);
    end
    // Let one idle cycle pass so a stray second done would be seen.
    @(negedge clk);
    checks++;
    if (w_q.size() != 0 || a_q.size() != 0 || i_q.size() != 0 || d_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing events: got pending w=%0d a=%0d inst=%0d done=%0d, required 0",
               name, w_q.size(), a_q.size(), i_q.size(), d_q.size());
    end
    w_q.delete();
    a_q.delete();
    i_q.delete();
    d_q.delete();
    active = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({w_rd_en, a_rd_en, w_rd_addr, a_rd_addr, inst_w, is_os, act_2b_mode, busy, done}
        !== 30'd0) begin
      errors++;
      $display("FAIL reset outputs: got w_en=%b a_en=%b w=%h a=%h inst=%b os=%b a2=%b busy=%b done=%b, required all 0",
               w_rd_en, a_rd_en, w_rd_addr, a_rd_addr, inst_w, is_os, act_2b_mode, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ws_tile();
    drive_tile("ws_tile", 1'b0, 1'b0, 4, 11'h010, 11'h100, 11, 4, -100);
  endtask

  task automatic test_os_tile();
    drive_tile("os_tile", 1'b1, 1'b1, 3, 11'h000, 11'h040, 4, 8, -100);
  endtask

  task automatic test_len_zero();
    drive_tile("len_zero", 1'b0, 1'b0, 0, 11'h123, 11'h456, 0, 0, -100);
    drive_tile("len_zero_os", 1'b1, 1'b0, 0, 11'h123, 11'h456, 0, 0, -100);
  endtask

  task automatic test_restart_ignored();
    drive_tile("restart", 1'b0, 1'b0, 6, 11'h200, 11'h300, 15, 6, 11);
  endtask

  task automatic test_reset_abort();
    ev_t ev;
    for (int n = 0; n < 3; n++) begin
      ev.rel = n; ev.val = 11'h020 + 11'(n); w_q.push_back(ev);
    end
    for (int n = 1; n < 3; n++) begin
      ev.rel = n; ev.val = 11'd1; i_q.push_back(ev);
    end
    @(negedge clk);
    cfg_is_os  = 1'b0;
    cfg_act_2b = 1'b1;
    cfg_len    = 8'd4;
    cfg_w_base = 11'h020;
    cfg_a_base = 11'h030;
    start      = 1'b1;
    t0         = cyc + 1;
    exp_os     = 1'b0;
    exp_a2     = 1'b1;
    active     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    // Third WLOAD cycle is on the bus now; reset takes effect at the next edge.
    reset  = 1'b1;
    active = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if ({w_rd_en, a_rd_en, w_rd_addr, a_rd_addr, inst_w, is_os, act_2b_mode, busy, done}
        !== 30'd0) begin
      errors++;
      $display("FAIL abort outputs: got w_en=%b w=%h inst=%b os=%b a2=%b busy=%b done=%b, required all 0",
               w_rd_en, w_rd_addr, inst_w, is_os, act_2b_mode, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (w_q.size() != 0 || i_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort residue: got pending w=%0d inst=%0d busy=%b, required 0 0 0",
               w_q.size(), i_q.size(), busy);
    end
    w_q.delete();
    i_q.delete();
    drive_tile("after_abort", 1'b0, 1'b1, 5, 11'h020, 11'h030, 12, 5, -100);
  endtask

  task automatic test_addr_wrap();
    drive_tile("addr_wrap", 1'b0, 1'b0, 4, 11'h7FC, 11'h7FE, 9, 8, -100);
  endtask

  task automatic test_back_to_back();
    drive_tile("long_os", 1'b1, 1'b0, 255, 11'h000, 11'h7F0, 0, 8, -100);
    drive_tile("b2b_ws", 1'b0, 1'b1, 2, 11'h3F8, 11'h001, 12, 2, -100);
  endtask

  initial begin
    test_reset();
    test_ws_tile();
    test_os_tile();
    test_len_zero();
    test_restart_ignored();
    test_reset_abort();
    test_addr_wrap();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
